// File: rtl/score_ctrl_pkg.sv
// score_ctrl_pkg: shared state encoding and default limits for the score display controller.
package score_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLASH, OVER} state_t;
    localparam int DEF_MAX_POINTS  = 999;
    localparam int DEF_LEVEL_STEP  = 100;
    localparam int DEF_MAX_LEVEL   = 9;
    localparam int DEF_TICK_DIV    = 25000000;
    localparam int DEF_FLASH_TICKS = 6;
endpackage

// File: rtl/blink_tick_gen.sv
// blink_tick_gen: free-running divide-by-TICK_DIV prescaler with synchronous clear and one-cycle tick.
module blink_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = !clear && cnt == W'(TICK_DIV - 1);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= (clear || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/score_display_controller.sv
// score_display_controller: accepts point awards, keeps a saturating score and level,
// and blinks the display on each level-up before taking further awards.
module score_display_controller
    import score_ctrl_pkg::*;
#(
    parameter int MAX_POINTS  = DEF_MAX_POINTS,
    parameter int LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int FLASH_TICKS = DEF_FLASH_TICKS
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       add_valid,
    input  logic [3:0] add_amount,
    output logic       add_ready,
    output logic [9:0] points,
    output logic [3:0] level,
    output logic       blank,
    output logic       game_over
);
    localparam int FW = $clog2(FLASH_TICKS + 1);
    state_t        state, next_state;
    logic          tick, accept, lvl_up, last_tick;
    logic [10:0]   sum, next_threshold;
    logic [9:0]    sat;
    logic [3:0]    new_level;
    logic [FW-1:0] flash_cnt;

    blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (state != FLASH),
        .tick   (tick)
    );

    assign accept    = add_valid && state == RUN;
    assign sum       = {1'b0, points} + 11'(add_amount);
    assign sat       = sum > 11'(MAX_POINTS) ? 10'(MAX_POINTS) : sum[9:0];
    assign lvl_up    = {1'b0, sat} >= next_threshold && level < 4'(MAX_LEVEL);
    assign last_tick = tick && flash_cnt == FW'(FLASH_TICKS - 1);

    // Constant thresholds let a multi-level jump land on the right level with one flash.
    always_comb begin
        new_level = level;
        for (int k = 1; k <= MAX_LEVEL; k++)
            if ({1'b0, sat} >= 11'(k * LEVEL_STEP)) new_level = 4'(k);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (start) next_state = RUN;
        else case (state)
            RUN:     if (accept) next_state = lvl_up ? FLASH : (sat == 10'(MAX_POINTS) ? OVER : RUN);
            FLASH:   if (last_tick) next_state = points == 10'(MAX_POINTS) ? OVER : RUN;
            default: next_state = state;
        endcase
    end

    always_comb begin
        add_ready = state == RUN;
        game_over = state == OVER;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            points         <= '0;
            level          <= '0;
            blank          <= 1'b0;
            next_threshold <= 11'(LEVEL_STEP);
            flash_cnt      <= '0;
        end else if (start) begin
            points         <= '0;
            level          <= '0;
            blank          <= 1'b0;
            next_threshold <= 11'(LEVEL_STEP);
            flash_cnt      <= '0;
        end else if (accept) begin
            points <= sat;
            if (lvl_up) begin
                level          <= new_level;
                next_threshold <= 11'((int'(new_level) + 1) * LEVEL_STEP);
                blank          <= 1'b1;
                flash_cnt      <= '0;
            end
        end else if (state == FLASH && tick) begin
            flash_cnt <= flash_cnt + 1'b1;
            blank     <= last_tick ? 1'b0 : !blank;
        end
    end
endmodule

// File: tb/tb_score_display_controller.sv
// tb_score_display_controller: directed plus random awards checked against an arithmetic score model.
module tb_score_display_controller;
    localparam int TD = 4, FT = 6, MP = 999, LS = 100, ML = 9;
    localparam int M_IDLE = 0, M_RUN = 1, M_FLASH = 2, M_OVER = 3;

    logic       clock = 0, reset_n = 0, start = 0, add_valid = 0;
    logic [3:0] add_amount = 0;
    logic       add_ready, blank, game_over;
    logic [9:0] points;
    logic [3:0] level;

    int total = 0, bad = 0;
    int m_points = 0, m_level = 0, m_mode = M_IDLE, m_fc = 0;

    score_display_controller #(.TICK_DIV(TD), .FLASH_TICKS(FT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .add_valid (add_valid),
        .add_amount(add_amount),
        .add_ready (add_ready),
        .points    (points),
        .level     (level),
        .blank     (blank),
        .game_over (game_over)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":points"}, 32'(points), m_points);
        chk({tag, ":level"}, 32'(level), m_level);
        chk({tag, ":ready"}, 32'(add_ready), m_mode == M_RUN);
        chk({tag, ":blank"}, 32'(blank), m_mode == M_FLASH && (m_fc / TD) % 2 == 0);
        chk({tag, ":over"}, 32'(game_over), m_mode == M_OVER);
    endtask

    task automatic model_edge(input logic s, input logic v, input int a);
        int np, nl;
        if (s) begin
            m_points = 0; m_level = 0; m_mode = M_RUN;
        end else if (m_mode == M_RUN && v) begin
            np = m_points + a > MP ? MP : m_points + a;
            nl = np / LS > ML ? ML : np / LS;
            m_points = np;
            if (nl > m_level) begin
                m_level = nl; m_mode = M_FLASH; m_fc = 0;
            end else if (np == MP) m_mode = M_OVER;
        end else if (m_mode == M_FLASH) begin
            m_fc++;
            if (m_fc == TD * FT) m_mode = m_points == MP ? M_OVER : M_RUN;
        end
    endtask

    task automatic step(input logic s, input logic v, input int a, input string tag);
        start = s; add_valid = v; add_amount = 4'(a);
        @(posedge clock);
        model_edge(s, v, a);
        #1;
        start = 0;
        check_outs(tag);
    endtask

    initial begin
        int guard;
        #12;
        check_outs("reset");
        reset_n = 1;
        step(0, 1, 7, "idle_hold");
        step(1, 0, 0, "start");
        step(0, 1, 7, "t1_award7");
        chk("t1_points7", 32'(points), 7);
        repeat (5) step(0, 1, 15, "t2_fill");
        step(0, 1, 13, "t2_fill95");
        chk("t2_points95", 32'(points), 95);
        step(0, 1, 9, "t2_lvl");
        chk("t2_blank_on", 32'(blank), 1);
        repeat (TD * FT) step(0, 1, 3, "t2_flash");
        step(0, 1, 3, "t2_after");
        chk("t2_points107", 32'(points), 107);
        repeat (600)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15), "rand");
        step(1, 0, 0, "t3_start");
        guard = 0;
        while ((m_points < 990 || m_mode != M_RUN) && guard < 3000) begin
            step(0, m_points < 990, m_points + 15 > 990 ? 990 - m_points : 15, "t3_fill");
            guard++;
        end
        chk("t3_reached990", 32'(points), 990);
        step(0, 1, 15, "t3_sat");
        chk("t3_points999", 32'(points), 999);
        chk("t3_gameover", 32'(game_over), 1);
        repeat (5) step(0, 1, 15, "t3_ignored");
        step(1, 0, 0, "t4_start0");
        repeat (7) step(0, 1, 15, "t4_fill");
        repeat (5) step(0, 0, 0, "t4_flash");
        step(1, 0, 0, "t4_start");
        step(1, 0, 0, "t5_start0");
        repeat (7) step(0, 1, 15, "t5_fill");
        repeat (6) step(0, 0, 0, "t5_flash");
        @(negedge clock);
        reset_n = 0;
        #1;
        m_points = 0; m_level = 0; m_mode = M_IDLE; m_fc = 0;
        check_outs("t5_async");
        #10;
        reset_n = 1;
        repeat (3) step(0, 1, 5, "t5_idle");
        step(1, 0, 0, "t6_start0");
        step(0, 1, 4, "t6_award4");
        step(1, 1, 5, "t6_collide");
        chk("t6_points0", 32'(points), 0);
        step(0, 0, 0, "t6_idle");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score_display_controller.md
Name: score_display_controller

Overview:
Sequences the game score and level values driven into the seven-segment display top.
- Accepts point-award requests over a valid/ready handshake.
- Accumulates a saturating 0..999 score and derives a 0..9 level.
- On each level-up, runs a timed blink of the display (blank/unblank) before accepting further awards.
- Sits between the game logic and the display top; drives its points and level inputs plus a display blank.

Parameters:
MAX_POINTS, 999, saturation ceiling for points (must be <= 1023).
LEVEL_STEP, 100, points per level.
MAX_LEVEL, 9, level ceiling.
TICK_DIV, 25000000, clock cycles per blink half-period tick.
FLASH_TICKS, 6, number of ticks in a level-up blink (even; display toggles every tick).

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: clear score, level; enter RUN
add_valid  input  1  award request valid
add_amount  input  4  points to add (0..15)
add_ready  output  1  controller can accept an award this cycle
points  output  10  current score, to display points input
level  output  4  current level, to display level input
blank  output  1  1 = display blanked (driven during blink)
game_over  output  1  1 while in OVER state

Behaviour:
Reset (reset_n=0, asynchronous):
- state=IDLE; points=0; level=0; blank=0; game_over=0; add_ready=0.
- Tick prescaler and flash counter = 0.

States:
- IDLE: add_ready=0. start -> RUN (points=0, level=0).
- RUN: add_ready=1. An award is accepted on a cycle where add_valid && add_ready.
  - points update on the following edge: points <= min(points+add_amount, MAX_POINTS). Use an 11-bit internal sum.
  - new_level = min(new_points / LEVEL_STEP, MAX_LEVEL), computed by threshold compare against the registered next_threshold; no divider.
  - If new_level > level: level <= new_level (same edge) and -> FLASH. Prescaler and flash counter clear on entry.
  - Else if new_points == MAX_POINTS: -> OVER.
  - add_amount=0 accepted with no change.
- FLASH: add_ready=0; award requests held off (requester keeps add_valid).
  - blank starts 1 on the entry cycle.
  - blank toggles on each prescaler tick (every TICK_DIV cycles).
  - After FLASH_TICKS ticks: blank=0 and -> OVER if points==MAX_POINTS, else -> RUN.
- OVER: add_ready=0; game_over=1; blank=0; points and level frozen.

start handling:
- start in any state: clears points and level, blank=0, and enters RUN next cycle.
- start has priority over a simultaneous accepted award; that award is discarded.

Other rules:
- Multi-level jump (only possible with LEVEL_STEP<16) produces one flash only.
- Reset mid-FLASH returns to IDLE with blank=0 immediately (asynchronous).
- Latency: award accept to updated points/level = 1 cycle; to blank=1 = 1 cycle.
- Outputs are registered; no combinational path from add_valid to add_ready.

Decomposition:
Shared package score_ctrl_pkg:
- state typedef (IDLE, RUN, FLASH, OVER).
- Default constants MAX_POINTS, LEVEL_STEP, MAX_LEVEL.

One sub-module, blink_tick_gen:
- Parameterised TICK_DIV counter with clear input.
- Emits a one-cycle tick pulse.
- Reusable for the display digit-scan prescaler.

Test Plan:
1. Reset, then start pulse, then award 7 -> points=7, level=0, add_ready=1, blank=0 one cycle after accept.
2. TICK_DIV=4, FLASH_TICKS=6, points=95, award 9:
   - points=104 and level=1; blank=1 next cycle, toggling every 4 cycles for 6 ticks, then 0.
   - add_ready=0 for the whole flash.
   - A held add_valid award of 3 is accepted after the flash -> points=107.
3. Points=990, level=9, award 15 -> points saturates at 999, level stays 9, no flash, game_over=1, add_ready=0; later awards ignored.
4. Mid-FLASH start pulse -> blank=0 and state RUN next cycle, points=0, level=0.
5. Mid-FLASH reset_n low -> all outputs at reset values immediately, without waiting for a clock edge; stay in IDLE after release until start.
6. start and accepted award (amount 5) on the same cycle -> points=0; award discarded.
